// File: rtl/fifo_pkt_reader.sv
// Drains a show-ahead FIFO and streams header+payload packets onto a valid/ready port with SOP/EOP marks.
// Optional payload starvation timeout is compiled in with `define FIFO_RD_TIMEOUT_EN.
module fifo_pkt_reader #(
    parameter int DATA_WIDTH     = 8,
    parameter int ADDR_WIDTH     = 2,
    parameter int LEN_WIDTH      = 6,
    parameter int CNT_WIDTH      = 16,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] fifo_data,
    input  logic                  fifo_empty,
    output logic                  fifo_pop,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  out_sop,
    output logic                  out_eop,
    output logic [ADDR_WIDTH-1:0] out_dest,
    output logic                  busy,
    output logic [CNT_WIDTH-1:0]  pkt_cnt,
    output logic                  err_timeout
);

    typedef enum logic {HDR = 1'b0, PLD = 1'b1} state_t;

    state_t                state_q, state_d;
    logic [LEN_WIDTH-1:0]  rem_q, rem_d;
    logic [DATA_WIDTH-1:0] out_data_q, out_data_d;
    logic                  out_valid_q, out_valid_d;
    logic                  out_sop_q, out_sop_d;
    logic                  out_eop_q, out_eop_d;
    logic [ADDR_WIDTH-1:0] out_dest_q, out_dest_d;
    logic [CNT_WIDTH-1:0]  pkt_cnt_q, pkt_cnt_d;
    logic                  accept;

`ifdef FIFO_RD_TIMEOUT_EN
    localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [TMO_W-1:0]      tmo_q, tmo_d;
    logic                  err_q, err_d;
`endif

    // A pop is only allowed when the single output register is free or being drained this cycle.
    assign fifo_pop = !rst && !fifo_empty && (!out_valid_q || out_ready);
    assign accept   = out_valid_q && out_ready;

    // Next-state logic for the output register, framing FSM and counters.
    always_comb begin
        state_d     = state_q;
        rem_d       = rem_q;
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q;
        out_sop_d   = out_sop_q;
        out_eop_d   = out_eop_q;
        out_dest_d  = out_dest_q;
        pkt_cnt_d   = pkt_cnt_q;
        if (accept) begin
            out_valid_d = 1'b0;
            if (out_eop_q) begin
                pkt_cnt_d = pkt_cnt_q + CNT_WIDTH'(1);
            end else begin
                pkt_cnt_d = pkt_cnt_q;
            end
        end else begin
            out_valid_d = out_valid_q;
        end
        if (fifo_pop) begin
            out_data_d  = fifo_data;
            out_valid_d = 1'b1;
            case (state_q)
                HDR: begin
                    out_sop_d  = 1'b1;
                    out_dest_d = fifo_data[DATA_WIDTH-1 -: ADDR_WIDTH];
                    if (fifo_data[LEN_WIDTH-1:0] == LEN_WIDTH'(0)) begin
                        out_eop_d = 1'b1;
                        state_d   = HDR;
                    end else begin
                        out_eop_d = 1'b0;
                        rem_d     = fifo_data[LEN_WIDTH-1:0];
                        state_d   = PLD;
                    end
                end
                PLD: begin
                    out_sop_d = 1'b0;
                    rem_d     = rem_q - LEN_WIDTH'(1);
                    if (rem_q == LEN_WIDTH'(1)) begin
                        out_eop_d = 1'b1;
                        state_d   = HDR;
                    end else begin
                        out_eop_d = 1'b0;
                        state_d   = PLD;
                    end
                end
                default: begin
                    state_d = HDR;
                    rem_d   = LEN_WIDTH'(0);
                end
            endcase
        end else begin
            out_data_d = out_data_q;
        end
`ifdef FIFO_RD_TIMEOUT_EN
        tmo_d = tmo_q;
        err_d = err_q;
        if (state_q == PLD && !fifo_pop) begin
            if (fifo_empty) begin
                if (tmo_q == TMO_W'(TIMEOUT_CYCLES - 1)) begin
                    // Abandon the packet; a held payload beat becomes its closing beat.
                    err_d   = 1'b1;
                    tmo_d   = TMO_W'(0);
                    state_d = HDR;
                    rem_d   = LEN_WIDTH'(0);
                    if (out_valid_d && !out_sop_q) begin
                        out_eop_d = 1'b1;
                    end else begin
                        out_eop_d = out_eop_q;
                    end
                end else begin
                    tmo_d = tmo_q + TMO_W'(1);
                end
            end else begin
                tmo_d = tmo_q;
            end
        end else begin
            tmo_d = TMO_W'(0);
        end
`endif
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= HDR;
            rem_q       <= LEN_WIDTH'(0);
            out_data_q  <= DATA_WIDTH'(0);
            out_valid_q <= 1'b0;
            out_sop_q   <= 1'b0;
            out_eop_q   <= 1'b0;
            out_dest_q  <= ADDR_WIDTH'(0);
            pkt_cnt_q   <= CNT_WIDTH'(0);
`ifdef FIFO_RD_TIMEOUT_EN
            tmo_q       <= TMO_W'(0);
            err_q       <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            rem_q       <= rem_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            out_sop_q   <= out_sop_d;
            out_eop_q   <= out_eop_d;
            out_dest_q  <= out_dest_d;
            pkt_cnt_q   <= pkt_cnt_d;
`ifdef FIFO_RD_TIMEOUT_EN
            tmo_q       <= tmo_d;
            err_q       <= err_d;
`endif
        end
    end

    assign out_data  = out_data_q;
    assign out_valid = out_valid_q;
    assign out_sop   = out_sop_q;
    assign out_eop   = out_eop_q;
    assign out_dest  = out_dest_q;
    assign pkt_cnt   = pkt_cnt_q;
    assign busy      = (state_q == PLD) || out_valid_q;
`ifdef FIFO_RD_TIMEOUT_EN
    assign err_timeout = err_q;
`else
    assign err_timeout = 1'b0;
`endif

endmodule
